// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: word load strobe, blank control and the
// multiplexed segment/anode pins plus status.
interface seg7_scan_driver_if #(
  parameter int unsigned DIGITS = 4
) ();

  logic                  load;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [DIGITS-1:0]     dp_in;
  logic                  blank;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  err;
  logic                  frame_done;

  modport master (
    output load, bcd_in, dp_in, blank,
    input  seg, dp, an, err, frame_done
  );

  modport slave (
    input  load, bcd_in, dp_in, blank,
    output seg, dp, an, err, frame_done
  );

endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit BCD to 7-segment driver with frame-synchronous word updates.
// Define SEG7_LZ_BLANK_EN to suppress leading zeros (digit 0 always shown).
module seg7_scan_driver #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CntW-1:0]   CntLast = CntW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0]   IdxLast = IdxW'(DIGITS - 1);
  localparam logic [6:0]        SegOff  = {7{SEG_ACTIVE_LOW}};
  localparam logic              DpOff   = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] AnOff   = {DIGITS{AN_ACTIVE_LOW}};

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [4*DIGITS-1:0] hold_q, hold_d;
  logic [DIGITS-1:0]   hold_dp_q, hold_dp_d;
  logic                pending_q, pending_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                err_q, err_d;
  logic                frame_done_q, frame_done_d;

  logic                slot_end;
  logic                boundary;
  logic [3:0]          nibs [DIGITS];
  logic [DIGITS-1:0]   lead_zero;
  logic [6:0]          seg_lit;
  logic [DIGITS-1:0]   an_sel;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] g;
    unique case (nib)
      4'd0:    g = 7'b1111110;
      4'd1:    g = 7'b0110000;
      4'd2:    g = 7'b1101101;
      4'd3:    g = 7'b1111001;
      4'd4:    g = 7'b0110011;
      4'd5:    g = 7'b1011011;
      4'd6:    g = 7'b1011111;
      4'd7:    g = 7'b1110000;
      4'd8:    g = 7'b1111111;
      4'd9:    g = 7'b1111011;
      default: g = 7'b1001111;
    endcase
    return g;
  endfunction

  // Scan position
  always_comb begin
    slot_end = (cnt_q == CntLast);
    boundary = slot_end && (idx_q == IdxLast);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
  end

  // Words only reach the display register on a frame boundary so no frame is ever mixed.
  always_comb begin
    hold_d    = hold_q;
    hold_dp_d = hold_dp_q;
    pending_d = pending_q;
    disp_d    = disp_q;
    disp_dp_d = disp_dp_q;
    if (boundary) begin
      if (bus.load) begin
        disp_d    = bus.bcd_in;
        disp_dp_d = bus.dp_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = hold_q;
        disp_dp_d = hold_dp_q;
        pending_d = 1'b0;
      end
    end else if (bus.load) begin
      hold_d    = bus.bcd_in;
      hold_dp_d = bus.dp_in;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      nibs[k] = disp_q[4*k +: 4];
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  // A digit is suppressed while it and every more-significant digit are zero.
  always_comb begin
    logic run;
    lead_zero = '0;
    run       = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      run          = run && (nibs[k] == 4'd0);
      lead_zero[k] = run;
    end
  end
`else
  assign lead_zero = '0;
`endif

  // Registered pin outputs, including the first-clock-of-slot anode gap against ghosting.
  always_comb begin
    seg_lit = lead_zero[idx_q] ? 7'b0000000 : decode(nibs[idx_q]);
    an_sel  = '0;
    if (!bus.blank && (cnt_q != '0)) begin
      an_sel[idx_q] = 1'b1;
    end
    seg_d = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
    dp_d  = disp_dp_q[idx_q] ^ SEG_ACTIVE_LOW;
    an_d  = AN_ACTIVE_LOW ? ~an_sel : an_sel;
    err_d = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      err_d = err_d | (nibs[k] > 4'd9);
    end
    frame_done_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      hold_q       <= '0;
      hold_dp_q    <= '0;
      pending_q    <= 1'b0;
      disp_q       <= '0;
      disp_dp_q    <= '0;
      seg_q        <= SegOff;
      dp_q         <= DpOff;
      an_q         <= AnOff;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      hold_dp_q    <= hold_dp_d;
      pending_q    <= pending_d;
      disp_q       <= disp_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.err        = err_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (DIGITS=4, SCAN_DIV=4): stimulus queues expected
// frames, a negedge monitor checks each queued frame slot by slot from its frame_done pulse.
module tb_seg7_scan_driver;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S6 = 7'b1011111;
  localparam logic [6:0] S7 = 7'b1110000;
  localparam logic [6:0] S8 = 7'b1111111;
  localparam logic [6:0] S9 = 7'b1111011;
  localparam logic [6:0] SE = 7'b1001111;
  localparam logic [6:0] SX = 7'b0000000;

  typedef struct packed {
    logic [27:0] segs;  // digit k at [7k +: 7]
    logic [3:0]  dps;
    logic        err;
    logic        blank;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.DIGITS(4)) bus ();

  seg7_scan_driver #(
    .DIGITS        (4),
    .SCAN_DIV      (4),
    .SEG_ACTIVE_LOW(1'b0),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t cur;
  bit   mon_active = 1'b0;
  int   ph = 0;
  logic last_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_frame();
    int t = 0;
    do begin
      tick(1);
      t++;
    end while (!bus.frame_done && t < 40);
    if (!bus.frame_done) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_frame timeout at %0t: got no frame_done, required one", $time);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || mon_active) && t < 200) begin
      tick(1);
      t++;
    end
    if (t >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle timeout at %0t: got %0d frames queued, required 0", $time,
               sb.size());
    end
  endtask

  task automatic do_load(input logic [15:0] w, input logic [3:0] d);
    bus.bcd_in = w;
    bus.dp_in  = d;
    bus.load   = 1'b1;
    tick(1);
    bus.load   = 1'b0;
  endtask

  task automatic push(input logic [27:0] s, input logic [3:0] d, input logic e,
                      input logic b);
    exp_t x;
    x.segs  = s;
    x.dps   = d;
    x.err   = e;
    x.blank = b;
    sb.push_back(x);
  endtask

  // Monitor: frame starts at the frame_done cycle (ph 0); phases 1..16 show digits 0..3.
  initial begin
    int         k;
    logic [3:0] exp_an;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_active = 1'b0;
        last_err   = 1'b0;
      end else begin
        if (mon_active) begin
          ph++;
          k = (ph - 1) / 4;
          if (cur.blank || ((ph - 1) % 4) == 0) exp_an = 4'b1111;
          else exp_an = ~(4'b0001 << k);
          chk($sformatf("an[ph%0d]", ph), 32'(bus.an), 32'(exp_an));
          chk($sformatf("seg[ph%0d]", ph), 32'(bus.seg), 32'(cur.segs[7*k +: 7]));
          chk($sformatf("dp[ph%0d]", ph), 32'(bus.dp), 32'(cur.dps[k]));
          chk($sformatf("frame_done[ph%0d]", ph), 32'(bus.frame_done), 32'(ph == 16));
          if (ph == 1) begin
            chk("err_new", 32'(bus.err), 32'(cur.err));
            last_err = cur.err;
          end
          if (ph == 16) mon_active = 1'b0;
        end
        if (!mon_active && bus.frame_done && sb.size() > 0) begin
          cur        = sb.pop_front();
          mon_active = 1'b1;
          ph         = 0;
          chk("err_prev", 32'(bus.err), 32'(last_err));
        end
      end
    end
  end

  initial begin
    bus.load   = 1'b0;
    bus.bcd_in = '0;
    bus.dp_in  = '0;
    bus.blank  = 1'b0;
    tick(3);
    chk("rst_an", 32'(bus.an), 32'h0000000f);
    chk("rst_seg", 32'(bus.seg), 32'h00000000);
    chk("rst_dp", 32'(bus.dp), 32'h00000000);
    chk("rst_err", 32'(bus.err), 32'h00000000);
    chk("rst_frame_done", 32'(bus.frame_done), 32'h00000000);
    rst = 1'b0;

    // Basic word
    do_load(16'h1234, 4'b0000);
    push({S1, S2, S3, S4}, 4'b0000, 1'b0, 1'b0);
    wait_idle();

    // Mid-frame load at cnt=2, idx=1: current frame stays old, next frame new
    wait_frame();
    push({S1, S2, S3, S4}, 4'b0000, 1'b0, 1'b0);
    tick(6);
    do_load(16'h5678, 4'b0101);
    push({S5, S6, S7, S8}, 4'b0101, 1'b0, 1'b0);
    wait_idle();

    // Invalid nibble raises err, then clears
    do_load(16'h00a9, 4'b0000);
    push({S0, S0, SE, S9}, 4'b0000, 1'b1, 1'b0);
    wait_idle();
    do_load(16'h0009, 4'b0000);
    push({S0, S0, S0, S9}, 4'b0000, 1'b0, 1'b0);
    wait_idle();

    // Load exactly on the boundary cycle; following frame must also be unchanged
    wait_frame();
    tick(15);
    do_load(16'h4321, 4'b1000);
    push({S4, S3, S2, S1}, 4'b1000, 1'b0, 1'b0);
    push({S4, S3, S2, S1}, 4'b1000, 1'b0, 1'b0);
    wait_idle();

    // Back-to-back loads mid-frame: last one wins
    wait_frame();
    tick(3);
    do_load(16'h1111, 4'b0000);
    do_load(16'h2222, 4'b0000);
    push({S2, S2, S2, S2}, 4'b0000, 1'b0, 1'b0);
    wait_idle();

    // Blank: anodes dark, frames keep coming
    bus.blank = 1'b1;
    push({S2, S2, S2, S2}, 4'b0000, 1'b0, 1'b1);
    push({S2, S2, S2, S2}, 4'b0000, 1'b0, 1'b1);
    wait_idle();
    bus.blank = 1'b0;

    // Leading zeros
    do_load(16'h0070, 4'b0000);
`ifdef SEG7_LZ_BLANK_EN
    push({SX, SX, S7, S0}, 4'b0000, 1'b0, 1'b0);
`else
    push({S0, S0, S7, S0}, 4'b0000, 1'b0, 1'b0);
`endif
    wait_idle();

    // Reset mid-frame with a pending word: pending discarded, scan restarts at digit 0
    wait_frame();
    tick(5);
    do_load(16'h9999, 4'b1111);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_an", 32'(bus.an), 32'h0000000f);
    chk("midrst_seg", 32'(bus.seg), 32'h00000000);
    chk("midrst_dp", 32'(bus.dp), 32'h00000000);
    chk("midrst_err", 32'(bus.err), 32'h00000000);
    chk("midrst_frame_done", 32'(bus.frame_done), 32'h00000000);
    push({S0, S0, S0, S0}, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      tick(1);
      chk("midrst_fd_low", 32'(bus.frame_done), 32'h00000000);
    end
    tick(1);
    chk("midrst_fd_first", 32'(bus.frame_done), 32'h00000001);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
